// File: rtl/cnn_load_sequencer.sv
// Load sequencer for one convolution job: unpacks header/payload streams for the
// data and filter matrices, packs payload into bus writes, then starts the accelerator.
module cnn_load_sequencer #(
  parameter int BUS_ADDR_WIDTH = 32,
  parameter int BUS_DATA_WIDTH = 64,
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_SIZE       = 4096,
  parameter int FILT_BASE_ADDR = 2048,
  localparam int NUM_WORDS = BUS_DATA_WIDTH / DATA_WIDTH,
  localparam int WE_WIDTH  = DATA_WIDTH / 8,
  localparam int DIM_WIDTH = $clog2(MAX_SIZE) + 1
) (
  input  logic                        clkIn,
  input  logic                        rstIn,
  input  logic [DATA_WIDTH-1:0]       dataIn,
  input  logic                        dataValidIn,
  input  logic                        dataLastIn,
  output logic                        dataReadyOut,
  input  logic [DATA_WIDTH-1:0]       filtIn,
  input  logic                        filtValidIn,
  input  logic                        filtLastIn,
  output logic                        filtReadyOut,
  output logic [DIM_WIDTH-1:0]        dataColsOut,
  output logic [DIM_WIDTH-1:0]        dataRowsOut,
  output logic [DIM_WIDTH-1:0]        filtColsOut,
  output logic [DIM_WIDTH-1:0]        filtRowsOut,
  output logic [BUS_ADDR_WIDTH-1:0]   addrOut,
  output logic [BUS_DATA_WIDTH/8-1:0] wrEnOut,
  output logic [BUS_DATA_WIDTH-1:0]   wrDataOut,
  output logic                        startOut,
  input  logic                        doneIn,
  output logic                        busyOut,
  output logic                        errorOut
);

  localparam int LANE_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int BE_W   = BUS_DATA_WIDTH / 8;

  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] DCOLS  = 4'd1;
  localparam logic [3:0] DROWS  = 4'd2;
  localparam logic [3:0] DLOAD  = 4'd3;
  localparam logic [3:0] DDRAIN = 4'd4;
  localparam logic [3:0] FCOLS  = 4'd5;
  localparam logic [3:0] FROWS  = 4'd6;
  localparam logic [3:0] FLOAD  = 4'd7;
  localparam logic [3:0] FDRAIN = 4'd8;
  localparam logic [3:0] START  = 4'd9;
  localparam logic [3:0] WAIT   = 4'd10;

  logic [3:0]                state_q, state_d;
  logic [DIM_WIDTH-1:0]      data_cols_q, data_cols_d, data_rows_q, data_rows_d;
  logic [DIM_WIDTH-1:0]      filt_cols_q, filt_cols_d, filt_rows_q, filt_rows_d;
  logic                      cols_big_q, cols_big_d;
  logic [DIM_WIDTH-1:0]      size_q, size_d;
  logic [DIM_WIDTH-1:0]      elem_q, elem_d;
  logic [LANE_W-1:0]         lane_q, lane_d;
  logic [NUM_WORDS-1:0]      fill_q, fill_d;
  logic [BUS_DATA_WIDTH-1:0] pack_q, pack_d;
  logic [BUS_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BUS_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [BE_W-1:0]           wr_en_q, wr_en_d;
  logic [BUS_DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                      start_q, start_d;
  logic                      busy_q, busy_d;
  logic                      error_q, error_d;

  logic                      is_filt, s_valid, s_last, beat, word_big, hdr_bad, group_full;
  logic [DATA_WIDTH-1:0]     s_word;
  logic [DIM_WIDTH-1:0]      cur_cols, elem_plus;
  logic [2*DIM_WIDTH-1:0]    prod;
  logic [NUM_WORDS-1:0]      fill_merge;
  logic [BUS_DATA_WIDTH-1:0] pack_merge;
  logic [BE_W-1:0]           we_merge;

  assign dataReadyOut = (state_q == DCOLS) || (state_q == DROWS) ||
                        (state_q == DLOAD) || (state_q == DDRAIN);
  assign filtReadyOut = (state_q == FCOLS) || (state_q == FROWS) ||
                        (state_q == FLOAD) || (state_q == FDRAIN);

  assign is_filt  = filtReadyOut;
  assign s_word   = is_filt ? filtIn : dataIn;
  assign s_valid  = is_filt ? filtValidIn : dataValidIn;
  assign s_last   = is_filt ? filtLastIn : dataLastIn;
  assign beat     = s_valid && (dataReadyOut || filtReadyOut);
  assign cur_cols = is_filt ? filt_cols_q : data_cols_q;
  assign word_big = s_word > DATA_WIDTH'(MAX_SIZE);
  assign prod     = (2*DIM_WIDTH)'(cur_cols) * (2*DIM_WIDTH)'(s_word[DIM_WIDTH-1:0]);
  // Oversized header words are flagged separately since the latched dims are truncated.
  assign hdr_bad  = s_last || (cur_cols == '0) || (s_word == '0) || cols_big_q ||
                    word_big || (prod > (2*DIM_WIDTH)'(MAX_SIZE));

  assign elem_plus  = elem_q + DIM_WIDTH'(1);
  assign group_full = (lane_q == LANE_W'(NUM_WORDS - 1)) || s_last;
  assign fill_merge = fill_q | (NUM_WORDS'(1) << lane_q);

  always_comb begin
    pack_merge = pack_q;
    pack_merge[lane_q*DATA_WIDTH +: DATA_WIDTH] = s_word;
  end

  generate
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_we
      assign we_merge[gi*WE_WIDTH +: WE_WIDTH] = {WE_WIDTH{fill_merge[gi]}};
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    data_cols_d = data_cols_q;
    data_rows_d = data_rows_q;
    filt_cols_d = filt_cols_q;
    filt_rows_d = filt_rows_q;
    cols_big_d  = cols_big_q;
    size_d      = size_q;
    elem_d      = elem_q;
    lane_d      = lane_q;
    fill_d      = fill_q;
    pack_d      = pack_q;
    addr_d      = addr_q;
    wr_addr_d   = wr_addr_q;
    wr_en_d     = '0;
    wr_data_d   = wr_data_q;
    start_d     = 1'b0;
    busy_d      = busy_q;
    error_d     = error_q;

    case (state_q)
      IDLE: begin
        if (dataValidIn) begin
          state_d = DCOLS;
          busy_d  = 1'b1;
          error_d = 1'b0;
        end
      end
      DCOLS, FCOLS: begin
        if (beat) begin
          if (is_filt) filt_cols_d = s_word[DIM_WIDTH-1:0];
          else         data_cols_d = s_word[DIM_WIDTH-1:0];
          cols_big_d = word_big;
          if (s_last) begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = is_filt ? FROWS : DROWS;
          end
        end
      end
      DROWS, FROWS: begin
        if (beat) begin
          if (is_filt) filt_rows_d = s_word[DIM_WIDTH-1:0];
          else         data_rows_d = s_word[DIM_WIDTH-1:0];
          if (hdr_bad) begin
            error_d = 1'b1;
            busy_d  = !s_last;
            state_d = s_last ? IDLE : (is_filt ? FDRAIN : DDRAIN);
          end else begin
            size_d  = prod[DIM_WIDTH-1:0];
            elem_d  = '0;
            lane_d  = '0;
            fill_d  = '0;
            pack_d  = '0;
            addr_d  = is_filt ? BUS_ADDR_WIDTH'(FILT_BASE_ADDR) : '0;
            state_d = is_filt ? FLOAD : DLOAD;
          end
        end
      end
      DLOAD, FLOAD: begin
        if (beat) begin
          elem_d = elem_plus;
          if (group_full) begin
            wr_en_d   = we_merge;
            wr_data_d = pack_merge;
            wr_addr_d = addr_q;
            addr_d    = addr_q + BUS_ADDR_WIDTH'(1);
            lane_d    = '0;
            fill_d    = '0;
            pack_d    = '0;
          end else begin
            pack_d = pack_merge;
            fill_d = fill_merge;
            lane_d = lane_q + LANE_W'(1);
          end
          if (s_last) begin
            if (elem_plus == size_q) begin
              state_d = is_filt ? START : FCOLS;
            end else begin
              error_d = 1'b1;
              busy_d  = 1'b0;
              state_d = IDLE;
            end
          end else if (elem_plus == size_q) begin
            error_d = 1'b1;
            state_d = is_filt ? FDRAIN : DDRAIN;
          end
        end
      end
      DDRAIN, FDRAIN: begin
        if (beat && s_last) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      START: begin
        start_d = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (doneIn) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkIn) begin
    if (rstIn) begin
      state_q     <= IDLE;
      data_cols_q <= '0;
      data_rows_q <= '0;
      filt_cols_q <= '0;
      filt_rows_q <= '0;
      cols_big_q  <= 1'b0;
      size_q      <= '0;
      elem_q      <= '0;
      lane_q      <= '0;
      fill_q      <= '0;
      pack_q      <= '0;
      addr_q      <= '0;
      wr_addr_q   <= '0;
      wr_en_q     <= '0;
      wr_data_q   <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_cols_q <= data_cols_d;
      data_rows_q <= data_rows_d;
      filt_cols_q <= filt_cols_d;
      filt_rows_q <= filt_rows_d;
      cols_big_q  <= cols_big_d;
      size_q      <= size_d;
      elem_q      <= elem_d;
      lane_q      <= lane_d;
      fill_q      <= fill_d;
      pack_q      <= pack_d;
      addr_q      <= addr_d;
      wr_addr_q   <= wr_addr_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      error_q     <= error_d;
    end
  end

  assign dataColsOut = data_cols_q;
  assign dataRowsOut = data_rows_q;
  assign filtColsOut = filt_cols_q;
  assign filtRowsOut = filt_rows_q;
  assign addrOut     = wr_addr_q;
  assign wrEnOut     = wr_en_q;
  assign wrDataOut   = wr_data_q;
  assign startOut    = start_q;
  assign busyOut     = busy_q;
  assign errorOut    = error_q;

endmodule

// File: tb/tb_cnn_load_sequencer.sv
// Directed bench for cnn_load_sequencer: bus writes are logged on the falling edge
// and compared against hand-computed tables per scenario.
module tb_cnn_load_sequencer;

  logic        clkIn = 1'b0;
  logic        rstIn = 1'b1;
  logic [31:0] dataIn = '0, filtIn = '0;
  logic        dataValidIn = 1'b0, dataLastIn = 1'b0, filtValidIn = 1'b0, filtLastIn = 1'b0;
  logic        dataReadyOut, filtReadyOut, startOut, busyOut, errorOut;
  logic        doneIn = 1'b0;
  logic [12:0] dataColsOut, dataRowsOut, filtColsOut, filtRowsOut;
  logic [31:0] addrOut;
  logic [7:0]  wrEnOut;
  logic [63:0] wrDataOut;

  int n_cmp = 0;
  int n_err = 0;
  int start_cnt = 0;
  logic [31:0] qa[$];
  logic [7:0]  qw[$];
  logic [63:0] qd[$];

  cnn_load_sequencer dut (
    .clkIn(clkIn), .rstIn(rstIn),
    .dataIn(dataIn), .dataValidIn(dataValidIn), .dataLastIn(dataLastIn), .dataReadyOut(dataReadyOut),
    .filtIn(filtIn), .filtValidIn(filtValidIn), .filtLastIn(filtLastIn), .filtReadyOut(filtReadyOut),
    .dataColsOut(dataColsOut), .dataRowsOut(dataRowsOut),
    .filtColsOut(filtColsOut), .filtRowsOut(filtRowsOut),
    .addrOut(addrOut), .wrEnOut(wrEnOut), .wrDataOut(wrDataOut),
    .startOut(startOut), .doneIn(doneIn), .busyOut(busyOut), .errorOut(errorOut)
  );

  always #5 clkIn = ~clkIn;

  always @(negedge clkIn) begin
    if (wrEnOut != 8'h00) begin
      qa.push_back(addrOut);
      qw.push_back(wrEnOut);
      qd.push_back(wrDataOut);
      $display("write addr=%0d we=%h data=%h", addrOut, wrEnOut, wrDataOut);
    end
    if (startOut) start_cnt++;
  end

  task automatic clr();
    qa.delete(); qw.delete(); qd.delete();
    start_cnt = 0;
  endtask

  // Called at a falling edge; returns at the falling edge after the beat transfers.
  task automatic push(input bit f, input logic [31:0] w, input bit l);
    int t = 0;
    if (f) begin filtIn = w; filtLastIn = l; filtValidIn = 1'b1; end
    else   begin dataIn = w; dataLastIn = l; dataValidIn = 1'b1; end
    while (!(f ? filtReadyOut : dataReadyOut) && t < 100) begin
      @(negedge clkIn);
      t++;
    end
    if (t >= 100) begin
      n_cmp++; n_err++;
      $display("FAIL handshake_timeout: ready not seen for stream %0d word %0d", f, w);
    end
    @(negedge clkIn);
    filtValidIn = 1'b0; filtLastIn = 1'b0; dataValidIn = 1'b0; dataLastIn = 1'b0;
  endtask

  task automatic send(input bit f, input logic [31:0] cols, input logic [31:0] rows,
                      input int n, input int first, input int gapmax);
    push(f, cols, 1'b0);
    push(f, rows, 1'b0);
    for (int i = 0; i < n; i++) begin
      push(f, 32'(first + i), (i == n - 1));
      repeat (gapmax > 0 ? $urandom_range(0, gapmax) : 0) @(negedge clkIn);
    end
  endtask

  task automatic wait_start();
    int t = 0;
    while (start_cnt == 0 && t < 100) begin
      @(negedge clkIn);
      t++;
    end
    n_cmp++;
    if (start_cnt == 0) begin
      n_err++;
      $display("FAIL start_timeout: startOut not seen within 100 cycles");
    end
  endtask

  task automatic pulse_done();
    doneIn = 1'b1;
    @(negedge clkIn);
    doneIn = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clkIn);
    n_cmp++;
    if ({busyOut, errorOut, startOut, dataReadyOut, filtReadyOut} !== 5'b0) begin
      n_err++; $display("FAIL reset_flags: got %b want 00000",
                        {busyOut, errorOut, startOut, dataReadyOut, filtReadyOut});
    end
    n_cmp++;
    if ({wrEnOut, addrOut, wrDataOut} !== '0) begin
      n_err++; $display("FAIL reset_bus: we=%h addr=%h data=%h want 0", wrEnOut, addrOut, wrDataOut);
    end
    n_cmp++;
    if ({dataColsOut, dataRowsOut, filtColsOut, filtRowsOut} !== '0) begin
      n_err++; $display("FAIL reset_dims: got %0d/%0d/%0d/%0d want 0", dataColsOut, dataRowsOut,
                        filtColsOut, filtRowsOut);
    end
    rstIn = 1'b0;
    @(negedge clkIn);
  endtask

  task automatic test_basic(input string tag);
    logic [31:0] ea[4] = '{32'd0, 32'd1, 32'd2, 32'd2048};
    logic [7:0]  ew[4] = '{8'hFF, 8'hFF, 8'hFF, 8'h0F};
    logic [63:0] ed[4] = '{{32'd2, 32'd1}, {32'd4, 32'd3}, {32'd6, 32'd5}, {32'd0, 32'd9}};
    clr();
    send(1'b0, 3, 2, 6, 1, 0);
    send(1'b1, 1, 1, 1, 9, 0);
    wait_start();
    repeat (3) @(negedge clkIn);
    n_cmp++;
    if ({dataColsOut, dataRowsOut, filtColsOut, filtRowsOut} !== {13'd3, 13'd2, 13'd1, 13'd1}) begin
      n_err++; $display("FAIL %s_dims: got %0d/%0d/%0d/%0d want 3/2/1/1", tag, dataColsOut,
                        dataRowsOut, filtColsOut, filtRowsOut);
    end
    n_cmp++;
    if (start_cnt != 1 || errorOut !== 1'b0 || busyOut !== 1'b1) begin
      n_err++; $display("FAIL %s_start: starts=%0d err=%b busy=%b want 1/0/1", tag, start_cnt,
                        errorOut, busyOut);
    end
    pulse_done();
    n_cmp++;
    if (busyOut !== 1'b0) begin
      n_err++; $display("FAIL %s_busy_clear: busy=%b want 0", tag, busyOut);
    end
    n_cmp++;
    if (qa.size() != 4) begin
      n_err++; $display("FAIL %s_wr_count: got %0d want 4", tag, qa.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if ({qa[i], qw[i], qd[i]} !== {ea[i], ew[i], ed[i]}) begin
          n_err++; $display("FAIL %s_wr%0d: got a=%0d we=%h d=%h want a=%0d we=%h d=%h", tag, i,
                            qa[i], qw[i], qd[i], ea[i], ew[i], ed[i]);
        end
      end
    end
  endtask

  task automatic test_wait_busy();
    int bad = 0;
    clr();
    send(1'b0, 3, 2, 6, 1, 0);
    send(1'b1, 1, 1, 1, 9, 0);
    wait_start();
    for (int i = 0; i < 20; i++) begin
      if (busyOut !== 1'b1) bad++;
      @(negedge clkIn);
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL wait_busy_held: busy low in %0d of 20 cycles want 0", bad);
    end
    pulse_done();
    n_cmp++;
    if (busyOut !== 1'b0) begin
      n_err++; $display("FAIL wait_busy_clear: busy=%b want 0", busyOut);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (dataReadyOut !== 1'b0) bad++;
      @(negedge clkIn);
    end
    n_cmp++;
    if (bad != 0 || start_cnt != 1 || qa.size() != 4) begin
      n_err++; $display("FAIL wait_after: ready_hi=%0d starts=%0d writes=%0d want 0/1/4", bad,
                        start_cnt, qa.size());
    end
  endtask

  task automatic test_rows_zero();
    clr();
    send(1'b0, 3, 0, 3, 1, 0);
    repeat (3) @(negedge clkIn);
    n_cmp++;
    if ({errorOut, busyOut, dataReadyOut} !== 3'b100) begin
      n_err++; $display("FAIL rows0_flags: err/busy/ready=%b want 100", {errorOut, busyOut, dataReadyOut});
    end
    n_cmp++;
    if (qa.size() != 0 || start_cnt != 0) begin
      n_err++; $display("FAIL rows0_activity: writes=%0d starts=%0d want 0/0", qa.size(), start_cnt);
    end
  endtask

  task automatic test_early_last();
    clr();
    send(1'b0, 2, 2, 3, 1, 0);
    repeat (3) @(negedge clkIn);
    n_cmp++;
    if ({errorOut, busyOut} !== 2'b10 || start_cnt != 0) begin
      n_err++; $display("FAIL early_flags: err=%b busy=%b starts=%0d want 1/0/0", errorOut, busyOut,
                        start_cnt);
    end
    n_cmp++;
    if (qa.size() != 2) begin
      n_err++; $display("FAIL early_wr_count: got %0d want 2", qa.size());
    end else begin
      n_cmp++;
      if ({qa[1], qw[1], qd[1]} !== {32'd1, 8'h0F, 32'd0, 32'd3}) begin
        n_err++; $display("FAIL early_partial: got a=%0d we=%h d=%h want a=1 we=0f d=%h", qa[1],
                          qw[1], qd[1], {32'd0, 32'd3});
      end
    end
    test_basic("recover");
  endtask

  task automatic test_gaps();
    logic [31:0] ea[4] = '{32'd0, 32'd1, 32'd2, 32'd2048};
    logic [7:0]  ew[4] = '{8'hFF, 8'hFF, 8'h0F, 8'h0F};
    logic [63:0] ed[4] = '{{32'd2, 32'd1}, {32'd4, 32'd3}, {32'd0, 32'd5}, {32'd0, 32'd7}};
    clr();
    send(1'b0, 5, 1, 5, 1, 3);
    send(1'b1, 1, 1, 1, 7, 3);
    wait_start();
    repeat (2) @(negedge clkIn);
    pulse_done();
    n_cmp++;
    if (qa.size() != 4) begin
      n_err++; $display("FAIL gaps_wr_count: got %0d want 4", qa.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if ({qa[i], qw[i], qd[i]} !== {ea[i], ew[i], ed[i]}) begin
          n_err++; $display("FAIL gaps_wr%0d: got a=%0d we=%h d=%h want a=%0d we=%h d=%h", i,
                            qa[i], qw[i], qd[i], ea[i], ew[i], ed[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    clr();
    push(1'b0, 2, 1'b0);
    push(1'b0, 3, 1'b0);
    for (int i = 1; i <= 3; i++) push(1'b0, 32'(i), 1'b0);
    rstIn = 1'b1;
    @(negedge clkIn);
    n_cmp++;
    if ({busyOut, errorOut, startOut, dataReadyOut, wrEnOut, addrOut, wrDataOut,
         dataColsOut, dataRowsOut} !== '0) begin
      n_err++; $display("FAIL midrst_outputs: busy=%b ready=%b we=%h addr=%0d dims=%0d/%0d want 0",
                        busyOut, dataReadyOut, wrEnOut, addrOut, dataColsOut, dataRowsOut);
    end
    rstIn = 1'b0;
    repeat (4) @(negedge clkIn);
    n_cmp++;
    if (qa.size() != 1 || start_cnt != 0) begin
      n_err++; $display("FAIL midrst_activity: writes=%0d starts=%0d want 1/0", qa.size(), start_cnt);
    end
    test_basic("after_rst");
  endtask

  initial begin
    test_reset();
    test_basic("basic");
    test_wait_busy();
    test_rows_zero();
    test_early_last();
    test_gaps();
    test_reset_mid();
    repeat (2) @(negedge clkIn);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
